// File: rtl/bit_serializer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bit_serializer_if : parallel handshake in, serial stream out
// Revision: 1.0
// ----------------------------------------------------------------------------
interface bit_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic             data_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             frame_start;
    logic             frame_end;
    logic             busy;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready,
        input  ser_out,
        input  ser_valid,
        input  frame_start,
        input  frame_end,
        input  busy
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready,
        output ser_out,
        output ser_valid,
        output frame_start,
        output frame_end,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/bit_serializer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bit_serializer : WIDTH-bit words in, one bit per clk out, one-word buffer
// Revision: 1.0
// ----------------------------------------------------------------------------
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    bit_serializer_if.slave  bus
);
    localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [0:0]        ST_IDLE  = 1'b0;
    localparam logic [0:0]        ST_SHIFT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] buf_data_q, buf_data_d;
    logic             buf_full_q, buf_full_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             frame_start_q, frame_start_d;
    logic             frame_end_q, frame_end_d;
    logic             busy_q, busy_d;

    logic             accept;
    logic             load;
    logic             last_bit;
    logic [WIDTH-1:0] shreg_shifted;
    logic             head_d;

    // Output end of the shift register depends on bit order
    if (MSB_FIRST) begin : g_msb_first
        assign shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
        assign head_d        = shreg_d[WIDTH-1];
    end else begin : g_lsb_first
        assign shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
        assign head_d        = shreg_d[0];
    end

    assign accept   = bus.data_valid && !buf_full_q;
    assign last_bit = (cnt_q == CNT_LAST);
    assign load     = buf_full_q && ((state_q == ST_IDLE) || last_bit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            buf_data_q    <= '0;
            buf_full_q    <= 1'b0;
            shreg_q       <= '0;
            cnt_q         <= '0;
            ser_out_q     <= IDLE_BIT;
            ser_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            buf_data_q    <= buf_data_d;
            buf_full_q    <= buf_full_d;
            shreg_q       <= shreg_d;
            cnt_q         <= cnt_d;
            ser_out_q     <= ser_out_d;
            ser_valid_q   <= ser_valid_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            busy_q        <= busy_d;
        end
    end

    // Accept and load are exclusive: accept needs an empty buffer, load a full one
    always_comb begin
        state_d    = state_q;
        buf_data_d = buf_data_q;
        buf_full_d = buf_full_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;

        if (accept) begin
            buf_data_d = bus.data_in;
            buf_full_d = 1'b1;
        end

        if (load) begin
            state_d    = ST_SHIFT;
            shreg_d    = buf_data_q;
            cnt_d      = '0;
            buf_full_d = 1'b0;
        end else if (state_q == ST_SHIFT) begin
            if (last_bit) begin
                state_d = ST_IDLE;
                shreg_d = '0;
                cnt_d   = '0;
            end else begin
                shreg_d = shreg_shifted;
                cnt_d   = cnt_q + 1'b1;
            end
        end
    end

    // Outputs are decoded from next-state values so they register with the state
    always_comb begin
        ser_valid_d   = (state_d == ST_SHIFT);
        ser_out_d     = ser_valid_d ? head_d : IDLE_BIT;
        frame_start_d = ser_valid_d && (cnt_d == '0);
        frame_end_d   = ser_valid_d && (cnt_d == CNT_LAST);
        busy_d        = ser_valid_d || buf_full_d;
    end

    assign bus.data_ready  = !buf_full_q;
    assign bus.ser_out     = ser_out_q;
    assign bus.ser_valid   = ser_valid_q;
    assign bus.frame_start = frame_start_q;
    assign bus.frame_end   = frame_end_q;
    assign bus.busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_bit_serializer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_bit_serializer : directed checks of MSB-first and LSB-first serializers
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_bit_serializer;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bit_serializer_if #(.WIDTH(8)) m_if ();
    bit_serializer_if #(.WIDTH(8)) l_if ();

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m_if)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_lsb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (l_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Stream monitor for the MSB-first instance
    logic [31:0] mon_stream = '0;
    logic [31:0] fs_mask    = '0;
    logic [31:0] fe_mask    = '0;
    int          mon_bits   = 0;
    int          mon_first  = 0;
    int          mon_last   = 0;
    int          mon_acc    = 0;
    int          cyc        = 0;
    bit          saw_stall  = 1'b0;

    always begin
        @(negedge clk);
        #1;
        cyc++;
        if (rst_n) begin
            if (m_if.data_valid && m_if.data_ready)  mon_acc++;
            if (m_if.data_valid && !m_if.data_ready) saw_stall = 1'b1;
            if (m_if.ser_valid) begin
                if (mon_bits == 0) mon_first = cyc;
                mon_last = cyc;
                if (mon_bits < 32) begin
                    if (m_if.frame_start) fs_mask[mon_bits] = 1'b1;
                    if (m_if.frame_end)   fe_mask[mon_bits] = 1'b1;
                end
                mon_stream = {mon_stream[30:0], m_if.ser_out};
                mon_bits++;
            end
        end
    end

    task automatic mon_clear();
        mon_stream = '0;
        fs_mask    = '0;
        fe_mask    = '0;
        mon_bits   = 0;
        mon_first  = 0;
        mon_last   = 0;
        mon_acc    = 0;
        saw_stall  = 1'b0;
    endtask

    // Present a word and return just after the edge that accepts it
    task automatic send_word(input logic [7:0] w);
        int n;
        n = 0;
        @(negedge clk);
        m_if.data_in    = w;
        m_if.data_valid = 1'b1;
        while (!m_if.data_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!m_if.data_ready) check_eq("accept_timeout", 32'(m_if.data_ready), 32'd1);
        @(posedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (m_if.busy && n < 100);
        check_eq("idle_timeout", 32'(m_if.busy), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    logic [7:0] w;

    initial begin
        m_if.data_in    = 8'hFF;
        m_if.data_valid = 1'b1;
        l_if.data_in    = 8'hFF;
        l_if.data_valid = 1'b1;

        // Reset held with valid asserted
        repeat (3) @(negedge clk);
        check_eq("rst_ser_valid", 32'(m_if.ser_valid), 32'd0);
        check_eq("rst_ser_out",   32'(m_if.ser_out),   32'd0);
        check_eq("rst_ready",     32'(m_if.data_ready), 32'd1);
        check_eq("rst_busy",      32'(m_if.busy),       32'd0);
        check_eq("rst_lsb_out",   32'(l_if.ser_out),    32'd1);
        check_eq("rst_lsb_ready", 32'(l_if.data_ready), 32'd1);
        m_if.data_valid = 1'b0;
        l_if.data_valid = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("post_rst_no_capture", 32'(m_if.ser_valid), 32'd0);
        check_eq("post_rst_busy",       32'(m_if.busy),      32'd0);

        // Single word 0110_1010, cycle accurate
        w = 8'b0110_1010;
        send_word(w);
        @(negedge clk);
        m_if.data_valid = 1'b0;
        check_eq("sw_buffered_busy",  32'(m_if.busy),       32'd1);
        check_eq("sw_buffered_ready", 32'(m_if.data_ready), 32'd0);
        check_eq("sw_buffered_valid", 32'(m_if.ser_valid),  32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_eq($sformatf("sw_bit%0d", i),   32'(m_if.ser_out),     32'(w[7-i]));
            check_eq($sformatf("sw_valid%0d", i), 32'(m_if.ser_valid),   32'd1);
            check_eq($sformatf("sw_fs%0d", i),    32'(m_if.frame_start), 32'(i == 0));
            check_eq($sformatf("sw_fe%0d", i),    32'(m_if.frame_end),   32'(i == 7));
        end
        @(negedge clk);
        check_eq("sw_end_valid", 32'(m_if.ser_valid), 32'd0);
        check_eq("sw_end_out",   32'(m_if.ser_out),   32'd0);
        check_eq("sw_end_busy",  32'(m_if.busy),      32'd0);

        // Back-to-back B5, 0F
        @(negedge clk);
        mon_clear();
        send_word(8'hB5);
        send_word(8'h0F);
        @(negedge clk);
        m_if.data_valid = 1'b0;
        wait_idle();
        check_eq("b2b_bits",   32'(mon_bits),                   32'd16);
        check_eq("b2b_stream", {16'h0, mon_stream[15:0]},       32'h0000_B50F);
        check_eq("b2b_contig", 32'(mon_last - mon_first + 1),   32'd16);
        check_eq("b2b_fs",     fs_mask,                         32'h0000_0101);
        check_eq("b2b_fe",     fe_mask,                         32'h0000_8080);
        check_eq("b2b_acc",    32'(mon_acc),                    32'd2);

        // Backpressure with valid held high: AA, 55, FF
        @(negedge clk);
        mon_clear();
        send_word(8'hAA);
        send_word(8'h55);
        send_word(8'hFF);
        @(negedge clk);
        m_if.data_valid = 1'b0;
        wait_idle();
        check_eq("bp_bits",   32'(mon_bits),                 32'd24);
        check_eq("bp_stream", {8'h0, mon_stream[23:0]},      32'h00AA_55FF);
        check_eq("bp_contig", 32'(mon_last - mon_first + 1), 32'd24);
        check_eq("bp_fs",     fs_mask,                       32'h0001_0101);
        check_eq("bp_fe",     fe_mask,                       32'h0080_8080);
        check_eq("bp_acc",    32'(mon_acc),                  32'd3);
        check_eq("bp_stall",  32'(saw_stall),                32'd1);

        // LSB-first instance, idle bit 1
        w = 8'b0000_0110;
        @(negedge clk);
        l_if.data_in    = w;
        l_if.data_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        l_if.data_valid = 1'b0;
        check_eq("lsb_pre_valid", 32'(l_if.ser_valid), 32'd0);
        check_eq("lsb_pre_out",   32'(l_if.ser_out),   32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_eq($sformatf("lsb_bit%0d", i),   32'(l_if.ser_out),   32'(w[i]));
            check_eq($sformatf("lsb_valid%0d", i), 32'(l_if.ser_valid), 32'd1);
        end
        @(negedge clk);
        check_eq("lsb_idle_out",   32'(l_if.ser_out),   32'd1);
        check_eq("lsb_idle_valid", 32'(l_if.ser_valid), 32'd0);

        // Mid-word asynchronous reset: C3 shifting, 3C buffered
        send_word(8'hC3);
        send_word(8'h3C);
        @(negedge clk);
        m_if.data_valid = 1'b0;
        @(negedge clk);
        check_eq("mid_pre_valid", 32'(m_if.ser_valid), 32'd1);
        check_eq("mid_pre_busy",  32'(m_if.busy),      32'd1);
        check_eq("mid_pre_full",  32'(m_if.data_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        m_if.data_in    = 8'hAA;
        m_if.data_valid = 1'b1;
        #1;
        check_eq("mid_rst_valid", 32'(m_if.ser_valid),   32'd0);
        check_eq("mid_rst_out",   32'(m_if.ser_out),     32'd0);
        check_eq("mid_rst_fs",    32'(m_if.frame_start), 32'd0);
        check_eq("mid_rst_fe",    32'(m_if.frame_end),   32'd0);
        check_eq("mid_rst_busy",  32'(m_if.busy),        32'd0);
        check_eq("mid_rst_ready", 32'(m_if.data_ready),  32'd1);
        repeat (2) @(negedge clk);
        m_if.data_valid = 1'b0;
        rst_n = 1'b1;
        mon_clear();
        repeat (20) @(negedge clk);
        check_eq("mid_post_bits", 32'(mon_bits),  32'd0);
        check_eq("mid_post_busy", 32'(m_if.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
